// File: rtl/wf_slot_allocator.sv
// Wavefront-slot allocator: owns the slot vacancy register, grants the
// lowest free slot to the dispatcher and accepts releases from retire logic.
// Optional build macro: ALLOC_ERR_CHECK_EN adds a sticky alloc_err output
// flagging releases of already-vacant or out-of-range slots.
module wf_slot_allocator #(
  parameter int unsigned NUM_SLOTS = 40,
  parameter int unsigned WFID_W    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req,
  output logic                 alloc_gnt,
  output logic [WFID_W-1:0]    alloc_wfid,
  input  logic                 rel_valid,
  input  logic [WFID_W-1:0]    rel_wfid,
  output logic [NUM_SLOTS-1:0] vacant,
  output logic [WFID_W-1:0]    free_count,
  output logic                 full
`ifdef ALLOC_ERR_CHECK_EN
  ,
  output logic                 alloc_err
`endif
);

  localparam logic [NUM_SLOTS-1:0] SLOT_ONE = NUM_SLOTS'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e                 state_q;
  logic [NUM_SLOTS-1:0]   vacant_q;
  logic [NUM_SLOTS-1:0]   vacant_d;
  logic [WFID_W-1:0]      free_count_q;
  logic [WFID_W-1:0]      free_count_d;
  logic                   full_q;
  logic                   gnt_q;
  logic [WFID_W-1:0]      wfid_q;

  logic                   pick_valid;
  logic [WFID_W-1:0]      pick_idx;
  logic                   do_grant;
  logic                   rel_in_range;
  logic [NUM_SLOTS-1:0]   rel_onehot;
  logic [NUM_SLOTS-1:0]   gnt_onehot;

  // Lowest-index vacant slot from the pre-edge vacancy vector
  always_comb begin
    pick_valid = |vacant_q;
    pick_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (vacant_q[i]) pick_idx = WFID_W'(i);
    end
  end

  // Next vacancy vector: clear the granted slot, set the released slot
  always_comb begin
    do_grant     = alloc_req && pick_valid && (state_q != S_GRANT);
    rel_in_range = 32'(rel_wfid) < NUM_SLOTS;
    rel_onehot   = (rel_valid && rel_in_range) ? (SLOT_ONE << rel_wfid) : '0;
    gnt_onehot   = do_grant ? (SLOT_ONE << pick_idx) : '0;
    vacant_d     = (vacant_q & ~gnt_onehot) | rel_onehot;
  end

  // Population count of the next vacancy vector
  always_comb begin
    free_count_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      free_count_d = free_count_d + WFID_W'(vacant_d[i]);
    end
  end

  // Allocation FSM and registered occupancy state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      vacant_q     <= '1;
      free_count_q <= WFID_W'(NUM_SLOTS);
      full_q       <= 1'b0;
      gnt_q        <= 1'b0;
      wfid_q       <= '0;
    end else begin
      vacant_q     <= vacant_d;
      free_count_q <= free_count_d;
      full_q       <= (vacant_d == '0);
      gnt_q        <= 1'b0;
      wfid_q       <= '0;
      case (state_q)
        S_IDLE: begin
          if (alloc_req) begin
            if (pick_valid) begin
              gnt_q   <= 1'b1;
              wfid_q  <= pick_idx;
              state_q <= S_GRANT;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_GRANT: state_q <= S_IDLE;
        S_WAIT: begin
          if (!alloc_req) begin
            state_q <= S_IDLE;
          end else if (pick_valid) begin
            gnt_q   <= 1'b1;
            wfid_q  <= pick_idx;
            state_q <= S_GRANT;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef ALLOC_ERR_CHECK_EN
  logic err_q;
  logic bad_rel;

  // A release is bad if out of range or targeting a slot already free
  always_comb begin
    bad_rel = rel_valid && (!rel_in_range || (|(rel_onehot & vacant_q)));
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (bad_rel) begin
      err_q <= 1'b1;
    end
  end

  assign alloc_err = err_q;
`endif

  assign alloc_gnt  = gnt_q;
  assign alloc_wfid = wfid_q;
  assign vacant     = vacant_q;
  assign free_count = free_count_q;
  assign full       = full_q;

endmodule

// File: tb/tb_wf_slot_allocator.sv
// Self-checking bench for wf_slot_allocator: behavioural reference model
// feeding an expectation queue, a directed vector table, and hand-written
// multi-cycle sequences.
module tb_wf_slot_allocator;

  localparam int NUM_SLOTS = 40;
  localparam int WFID_W    = 6;

  localparam int M_IDLE  = 0;
  localparam int M_GRANT = 1;
  localparam int M_WAIT  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 alloc_req;
  logic                 alloc_gnt;
  logic [WFID_W-1:0]    alloc_wfid;
  logic                 rel_valid;
  logic [WFID_W-1:0]    rel_wfid;
  logic [NUM_SLOTS-1:0] vacant;
  logic [WFID_W-1:0]    free_count;
  logic                 full;
  logic                 alloc_err_w;

  wf_slot_allocator #(.NUM_SLOTS(NUM_SLOTS), .WFID_W(WFID_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .alloc_req  (alloc_req),
    .alloc_gnt  (alloc_gnt),
    .alloc_wfid (alloc_wfid),
    .rel_valid  (rel_valid),
    .rel_wfid   (rel_wfid),
    .vacant     (vacant),
    .free_count (free_count),
    .full       (full)
`ifdef ALLOC_ERR_CHECK_EN
    ,
    .alloc_err  (alloc_err_w)
`endif
  );

`ifndef ALLOC_ERR_CHECK_EN
  assign alloc_err_w = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic                 gnt;
    logic [WFID_W-1:0]    wfid;
    logic [NUM_SLOTS-1:0] vac;
    logic [WFID_W-1:0]    free;
    logic                 full;
    logic                 err;
  } exp_t;

  typedef struct {
    logic              r;
    logic              req;
    logic              rv;
    logic [WFID_W-1:0] rw;
    logic              gnt;
    logic [WFID_W-1:0] wfid;
    logic [WFID_W-1:0] free;
    logic              full;
    logic              err;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[12];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int                   m_state = M_IDLE;
  logic [NUM_SLOTS-1:0] m_vac   = '1;
  logic                 m_gnt   = 1'b0;
  logic [WFID_W-1:0]    m_wfid  = '0;
  logic                 m_err   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, advance the model, then compare after the edge
  task automatic step(input logic r, input logic q, input logic v, input logic [WFID_W-1:0] w);
    exp_t e;
    exp_t got;
    logic [NUM_SLOTS-1:0] clr;
    logic [NUM_SLOTS-1:0] setb;
    int p;
    rst       = r;
    alloc_req = q;
    rel_valid = v;
    rel_wfid  = w;
    if (!r) begin
      m_state = M_IDLE;
      m_vac   = '1;
      m_gnt   = 1'b0;
      m_wfid  = '0;
      m_err   = 1'b0;
    end else begin
      p = -1;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) if (m_vac[i]) p = i;
      clr    = '0;
      setb   = '0;
      m_gnt  = 1'b0;
      m_wfid = '0;
      case (m_state)
        M_IDLE: begin
          if (q) begin
            if (p >= 0) begin
              m_gnt = 1'b1; m_wfid = WFID_W'(p); clr[p] = 1'b1; m_state = M_GRANT;
            end else begin
              m_state = M_WAIT;
            end
          end
        end
        M_GRANT: m_state = M_IDLE;
        default: begin
          if (!q) begin
            m_state = M_IDLE;
          end else if (p >= 0) begin
            m_gnt = 1'b1; m_wfid = WFID_W'(p); clr[p] = 1'b1; m_state = M_GRANT;
          end
        end
      endcase
      if (v) begin
        if (int'(w) < NUM_SLOTS) begin
          if (m_vac[w]) m_err = 1'b1;
          setb[w] = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
      m_vac = (m_vac & ~clr) | setb;
    end
    e.gnt  = m_gnt;
    e.wfid = m_wfid;
    e.vac  = m_vac;
    e.free = WFID_W'($countones(m_vac));
    e.full = (m_vac == '0);
    e.err  = m_err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk("sb_gnt",  64'(alloc_gnt),  64'(got.gnt));
    chk("sb_wfid", 64'(alloc_wfid), 64'(got.wfid));
    chk("sb_vac",  64'(vacant),     64'(got.vac));
    chk("sb_free", 64'(free_count), 64'(got.free));
    chk("sb_full", 64'(full),       64'(got.full));
`ifdef ALLOC_ERR_CHECK_EN
    chk("sb_err",  64'(alloc_err_w), 64'(got.err));
`endif
  endtask

  initial begin
    int gcount;
    int ngnt;

    //           r     req   rv    rw      gnt   wfid   free    full  err
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 6'd0,  1'b1, 6'd0, 6'd39, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0, 6'd39, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 6'd0,  1'b1, 6'd1, 6'd39, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 6'd45, 1'b0, 6'd0, 6'd39, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 6'd3,  1'b0, 6'd0, 6'd39, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 6'd1,  1'b0, 6'd0, 6'd40, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 6'd0,  1'b1, 6'd0, 6'd39, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 6'd0,  1'b0, 6'd0, 6'd39, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 6'd0,  1'b1, 6'd1, 6'd38, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 6'd63, 1'b0, 6'd0, 6'd38, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 6'd0, 6'd40, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 6'd0,  1'b1, 6'd0, 6'd39, 1'b0, 1'b0};

    rst = 1'b0; alloc_req = 1'b0; rel_valid = 1'b0; rel_wfid = '0;
    step(1'b0, 1'b0, 1'b0, 6'd0);
    step(1'b0, 1'b1, 1'b1, 6'd5);
    chk("reset_vacant", 64'(vacant), 64'(40'hFF_FFFF_FFFF));
    chk("reset_free",   64'(free_count), 64'd40);
    chk("reset_gnt",    64'(alloc_gnt), 64'd0);

    // Directed vector table
    for (int k = 0; k < 12; k++) begin
      step(tbl[k].r, tbl[k].req, tbl[k].rv, tbl[k].rw);
      chk($sformatf("tbl%0d_gnt", k),  64'(alloc_gnt),  64'(tbl[k].gnt));
      chk($sformatf("tbl%0d_wfid", k), 64'(alloc_wfid), 64'(tbl[k].wfid));
      chk($sformatf("tbl%0d_free", k), 64'(free_count), 64'(tbl[k].free));
      chk($sformatf("tbl%0d_full", k), 64'(full),       64'(tbl[k].full));
`ifdef ALLOC_ERR_CHECK_EN
      chk($sformatf("tbl%0d_err", k),  64'(alloc_err_w), 64'(tbl[k].err));
`endif
      if (k == 2) begin
        chk("same_cycle_vac0", 64'(vacant[0]), 64'd1);
        chk("same_cycle_vac1", 64'(vacant[1]), 64'd0);
      end
    end

    // Fill all 40 slots with alloc_req held
    step(1'b0, 1'b0, 1'b0, 6'd0);
    gcount = 0;
    for (int k = 0; k < 80; k++) begin
      step(1'b1, 1'b1, 1'b0, 6'd0);
      if ((k % 2) == 0) begin
        chk("fill_gnt", 64'(alloc_gnt), 64'd1);
        chk("fill_wfid", 64'(alloc_wfid), 64'(gcount));
        gcount++;
      end else begin
        chk("fill_gap", 64'(alloc_gnt), 64'd0);
      end
    end
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_free", 64'(free_count), 64'd0);
    ngnt = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 1'b0, 6'd0);
      if (alloc_gnt) ngnt++;
    end
    chk("full_no_gnt", 64'(ngnt), 64'd0);

    // Release slot 17 from WAIT with alloc_req held
    step(1'b1, 1'b1, 1'b1, 6'd17);
    chk("rel17_vac",  64'(vacant[17]), 64'd1);
    chk("rel17_gnt0", 64'(alloc_gnt), 64'd0);
    chk("rel17_full0", 64'(full), 64'd0);
    step(1'b1, 1'b1, 1'b0, 6'd0);
    chk("rel17_gnt",  64'(alloc_gnt), 64'd1);
    chk("rel17_wfid", 64'(alloc_wfid), 64'd17);
    chk("rel17_full", 64'(full), 64'd1);
    step(1'b1, 1'b1, 1'b0, 6'd0);
    step(1'b1, 1'b1, 1'b0, 6'd0);
    step(1'b1, 1'b1, 1'b0, 6'd0);

    // In WAIT: drop alloc_req, then release slot 9 -> no grant
    step(1'b1, 1'b0, 1'b0, 6'd0);
    step(1'b1, 1'b0, 1'b1, 6'd9);
    ngnt = 0;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b0, 6'd0);
      if (alloc_gnt) ngnt++;
    end
    chk("drop_no_gnt", 64'(ngnt), 64'd0);
    chk("drop_vac9",   64'(vacant[9]), 64'd1);
    chk("drop_free",   64'(free_count), 64'd1);

    // Five grants, then reset while in GRANT
    step(1'b0, 1'b0, 1'b0, 6'd0);
    for (int k = 0; k < 9; k++) step(1'b1, 1'b1, 1'b0, 6'd0);
    chk("pre_rst_gnt",  64'(alloc_gnt), 64'd1);
    chk("pre_rst_wfid", 64'(alloc_wfid), 64'd4);
    step(1'b0, 1'b1, 1'b1, 6'd2);
    chk("midrst_gnt",  64'(alloc_gnt), 64'd0);
    chk("midrst_vac",  64'(vacant), 64'(40'hFF_FFFF_FFFF));
    chk("midrst_free", 64'(free_count), 64'd40);
    step(1'b1, 1'b1, 1'b0, 6'd0);
    chk("postrst_gnt",  64'(alloc_gnt), 64'd1);
    chk("postrst_wfid", 64'(alloc_wfid), 64'd0);

    // Randomised traffic checked by the model
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0), WFID_W'($urandom_range(0, 47)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/wf_slot_allocator.md
Name: wf_slot_allocator

Overview:
- Owns the 40-entry wavefront-slot vacancy register and hands out free wavefront IDs to the dispatcher.
- Each grant clears a vacancy bit. Each completion or halt release sets one back.
- Sits between the workgroup dispatcher (allocation side) and the issue/retire logic (release side) as the single source of truth for slot occupancy.

Parameters:
- NUM_SLOTS, 40, number of wavefront slots; vacancy vector width.
- WFID_W, 6, width of a wavefront ID; must satisfy 2^WFID_W >= NUM_SLOTS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset).
- alloc_req  input  1  level request from dispatcher for one slot.
- alloc_gnt  output  1  one-cycle registered grant pulse.
- alloc_wfid  output  WFID_W  granted slot ID; valid only while alloc_gnt=1, otherwise 0.
- rel_valid  input  1  release strobe (wavefront done or halted).
- rel_wfid  input  WFID_W  slot ID being released.
- vacant  output  NUM_SLOTS  registered vacancy vector; 1 = free.
- free_count  output  WFID_W  registered number of set bits in vacant, 0..40.
- full  output  1  registered; 1 when vacant == 0.

Behaviour:
- Reset (rst=0 at edge), applies mid-operation too:
  - vacant = all ones; free_count = 40; full = 0.
  - alloc_gnt = 0; alloc_wfid = 0; FSM = IDLE.
  - In-flight requests and releases are discarded.
- FSM states:
  - IDLE:
    - alloc_req=1 and vacant!=0: select p = lowest-index set bit of vacant, clear vacant[p], load alloc_wfid=p, set alloc_gnt=1, go to GRANT.
    - alloc_req=1 and vacant==0: go to WAIT.
    - Otherwise stay in IDLE.
  - GRANT: alloc_gnt=1 for exactly this cycle. alloc_req is ignored. Next state is IDLE; alloc_gnt and alloc_wfid return to 0.
  - WAIT: each cycle, if vacant!=0, perform the IDLE grant action and go to GRANT. If alloc_req drops, return to IDLE with no grant.
- Latency and throughput:
  - Request sampled in cycle N produces alloc_gnt in cycle N+1.
  - At most one grant per two cycles.
  - The requester must observe alloc_gnt before treating the slot as owned.
- Release:
  - rel_valid=1 with rel_wfid < NUM_SLOTS sets vacant[rel_wfid] at the edge.
  - rel_wfid >= NUM_SLOTS is ignored.
  - Release of an already-vacant slot leaves vacant unchanged.
- Simultaneous grant and release in the same cycle:
  - Slot selection uses the pre-edge vacant value.
  - The next vacant = (vacant & ~onehot(p)) | onehot(rel_wfid).
  - A slot released in cycle N is first grantable in cycle N+1. WAIT therefore exits one cycle after the release strobe.
- Derived outputs:
  - free_count and full are computed from the next-state vacant and registered, so they always agree with vacant in the same cycle.
  - free_count never wraps: maximum 40, minimum 0.

Optional Feature:
- Macro ALLOC_ERR_CHECK_EN.
- When defined, adds output alloc_err (1 bit, sticky, cleared only by reset). It is set one cycle after either:
  - a release of an already-vacant slot, or
  - rel_wfid >= NUM_SLOTS.
- The state update is identical to the undefined build (bad releases still ignored).
- When undefined: no alloc_err port; bad releases are silently ignored.

Test Plan:
- Reset, then hold alloc_req=1 for 80 cycles -> grants with wfid 0,1,2,...,39 on alternating cycles; then full=1, free_count=0, FSM in WAIT, no further alloc_gnt.
- From full with alloc_req held, pulse rel_valid with rel_wfid=17 in cycle N -> vacant[17]=1 at N+1, alloc_gnt=1 with alloc_wfid=17 at N+2, full=1 again at N+2.
- Slot 0 occupied, slots 1..39 vacant; in the same cycle alloc_req=1 and rel_valid=1 with rel_wfid=0 -> grant of wfid=1 next cycle, vacant[0]=1, vacant[1]=0, free_count unchanged at 39.
- Release rel_wfid=45, then release of an already-vacant slot 3 -> vacant and free_count unchanged. With ALLOC_ERR_CHECK_EN, alloc_err=1 from the cycle after the first bad release and stays 1.
- Grant 5 slots, then drive rst=0 for one cycle mid-GRANT -> next cycle alloc_gnt=0, vacant all ones, free_count=40, FSM IDLE; a fresh request then grants wfid 0.
- In WAIT, drop alloc_req before any release, then release slot 9 -> no alloc_gnt issued; vacant[9]=1, free_count=1.
